// File: rtl/video_timing_gen_if.sv
// Pixel and raster-timing bundle between the timing generator (master) and the
// fetch/scandoubler logic that consumes it (slave).
interface video_timing_gen_if;
    logic [2:0] rin;
    logic [2:0] gin;
    logic [2:0] bin;
    logic [9:0] hcount;
    logic [8:0] vcount;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       hsync_ext_n;
    logic       vsync_ext_n;
    logic       csync_ext_n;
    logic [2:0] ri;
    logic [2:0] gi;
    logic [2:0] bi;

    modport master (
        input  rin, gin, bin,
        output hcount, vcount, active, line_start, frame_start,
               hsync_ext_n, vsync_ext_n, csync_ext_n, ri, gi, bi
    );

    modport slave (
        output rin, gin, bin,
        input  hcount, vcount, active, line_start, frame_start,
               hsync_ext_n, vsync_ext_n, csync_ext_n, ri, gi, bi
    );
endinterface

// File: rtl/video_timing_gen.sv
// 15 kHz PAL-style raster timing generator with 3:3:3 pixel blanking on clkvideo.
// Define CSYNC_SERRATION_EN for broad/equalising pulses on csync_ext_n.
module video_timing_gen #(
    parameter int H_TOTAL  = 384,
    parameter int H_SYNC   = 29,
    parameter int H_START  = 64,
    parameter int H_ACTIVE = 256,
    parameter int V_TOTAL  = 312,
    parameter int V_SYNC   = 3,
    parameter int V_START  = 40,
    parameter int V_ACTIVE = 208
) (
    input  logic               clkvideo,
    input  logic               rst,
    video_timing_gen_if.master vid
);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_START);
    localparam logic [10:0] H_ACT_HI = 11'(H_START + H_ACTIVE);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_LO = 10'(V_START);
    localparam logic [9:0]  V_ACT_HI = 10'(V_START + V_ACTIVE);

    logic [9:0]  h_next;
    logic [8:0]  v_next;
    logic [10:0] hx;
    logic [9:0]  vx;
    logic        hsync_next;
    logic        vsync_next;
    logic        active_next;
    logic        csync_next;

    always_comb begin
        // NOTE: defaults first so no path through the block can infer a latch.
        h_next = vid.hcount + 10'd1;
        v_next = vid.vcount;
        if (vid.hcount == H_LAST) begin
            h_next = '0;
            v_next = (vid.vcount == V_LAST) ? '0 : vid.vcount + 9'd1;
        end
    end

    // All decodes use the next counts so registered outputs line up with the counters.
    assign hx          = {1'b0, h_next};
    assign vx          = {1'b0, v_next};
    assign hsync_next  = (hx >= H_SYNC_E);
    assign vsync_next  = (vx >= V_SYNC_E);
    assign active_next = (hx >= H_ACT_LO) && (hx < H_ACT_HI) &&
                         (vx >= V_ACT_LO) && (vx < V_ACT_HI);

`ifdef CSYNC_SERRATION_EN
    localparam logic [10:0] H_HALF    = 11'(H_TOTAL / 2);
    localparam logic [10:0] H_BROAD_1 = 11'(H_TOTAL / 2 - H_SYNC);
    localparam logic [10:0] H_BROAD_2 = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] H_EQ_W    = 11'(H_SYNC / 2);
    localparam logic [10:0] H_EQ_2    = 11'(H_TOTAL / 2 + H_SYNC / 2);
    localparam logic [9:0]  V_EQ_HI   = 10'(V_SYNC + 2);
    localparam logic [9:0]  V_EQ_TAIL = 10'(V_TOTAL - 3);

    logic broad_line;
    logic eq_line;
    logic broad_low;
    logic eq_low;

    assign broad_line = (vx < V_SYNC_E);
    assign eq_line    = ((vx >= V_SYNC_E) && (vx <= V_EQ_HI)) || (vx >= V_EQ_TAIL);
    assign broad_low  = (hx < H_BROAD_1) || ((hx >= H_HALF) && (hx < H_BROAD_2));
    assign eq_low     = (hx < H_EQ_W) || ((hx >= H_HALF) && (hx < H_EQ_2));
    assign csync_next = broad_line ? !broad_low :
                        eq_line    ? !eq_low    : hsync_next;
`else
    assign csync_next = hsync_next & vsync_next;
`endif

    always_ff @(posedge clkvideo) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (rst) begin
            vid.hcount      <= H_LAST;
            vid.vcount      <= V_LAST;
            vid.active      <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.hsync_ext_n <= 1'b1;
            vid.vsync_ext_n <= 1'b1;
            vid.csync_ext_n <= 1'b1;
            vid.ri          <= 3'd0;
            vid.gi          <= 3'd0;
            vid.bi          <= 3'd0;
        end else begin
            vid.hcount      <= h_next;
            vid.vcount      <= v_next;
            vid.active      <= active_next;
            vid.line_start  <= (h_next == 10'd0);
            vid.frame_start <= (h_next == 10'd0) && (v_next == 9'd0);
            vid.hsync_ext_n <= hsync_next;
            vid.vsync_ext_n <= vsync_next;
            vid.csync_ext_n <= csync_next;
            // Colour belongs to the current counters, so blank on the current active flag.
            vid.ri          <= vid.active ? vid.rin : 3'd0;
            vid.gi          <= vid.active ? vid.gin : 3'd0;
            vid.bi          <= vid.active ? vid.bin : 3'd0;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default PAL timing plus a shrunken instance
// that exercises line/frame wrap and end-of-frame csync within a short run.
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    video_timing_gen_if vif ();
    video_timing_gen_if sif ();

    video_timing_gen u_dut (
        .clkvideo (clk),
        .rst      (rst),
        .vid      (vif)
    );

    video_timing_gen #(
        .H_TOTAL (20), .H_SYNC (4), .H_START (5), .H_ACTIVE (12),
        .V_TOTAL (12), .V_SYNC (2), .V_START (3), .V_ACTIVE (6)
    ) u_small (
        .clkvideo (clk),
        .rst      (rst_s),
        .vid      (sif)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_csync(input int h, input int v, input int ht,
                                       input int hs, input int vt, input int vs);
        logic hs_n;
        logic vs_n;
        hs_n = (h >= hs);
        vs_n = (v >= vs);
`ifdef CSYNC_SERRATION_EN
        if (v < vs)
            return !((h < ht / 2 - hs) || ((h >= ht / 2) && (h < ht - hs)));
        if (((v >= vs) && (v <= vs + 2)) || (v >= vt - 3))
            return !((h < hs / 2) || ((h >= ht / 2) && (h < ht / 2 + hs / 2)));
        return hs_n & vs_n;
`else
        return hs_n & vs_n;
`endif
    endfunction

    localparam int K_STOP = 100 * 384 + 200;

    int h_e, v_e;
    logic act_e, prev_act;
    logic [8:0] rgb, prev_rgb;
    logic [31:0] kb;
    logic prev_hs, prev_vs;
    int bad_hv, bad_act, bad_hs, bad_vs, bad_ls, bad_fs, bad_cs, bad_rgb;
    int hs_low_2l, hs_fall_n, hs_fall0, hs_fall1;
    int vs_low, vs_fall_n, vs_orphan, ls_2l, fs_cnt, first_ri_k, ri_nz, cs_low0, cs_low3;

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        {vif.rin, vif.gin, vif.bin} = 9'd0;
        {sif.rin, sif.gin, sif.bin} = 9'd0;
        repeat (5) tick();

        check("rst_hcount", 32'(vif.hcount), 383);
        check("rst_vcount", 32'(vif.vcount), 311);
        check("rst_active", 32'(vif.active), 0);
        check("rst_line_start", 32'(vif.line_start), 0);
        check("rst_frame_start", 32'(vif.frame_start), 0);
        check("rst_hsync", 32'(vif.hsync_ext_n), 1);
        check("rst_vsync", 32'(vif.vsync_ext_n), 1);
        check("rst_csync", 32'(vif.csync_ext_n), 1);
        check("rst_rgb", 32'({vif.ri, vif.gi, vif.bi}), 0);

        rst = 1'b0;
        tick();
        check("rel_hcount", 32'(vif.hcount), 0);
        check("rel_vcount", 32'(vif.vcount), 0);
        check("rel_frame_start", 32'(vif.frame_start), 1);
        check("rel_line_start", 32'(vif.line_start), 1);
        check("rel_hsync", 32'(vif.hsync_ext_n), 0);
        check("rel_vsync", 32'(vif.vsync_ext_n), 0);

        {bad_hv, bad_act, bad_hs, bad_vs, bad_ls, bad_fs, bad_cs, bad_rgb} = '0;
        {hs_low_2l, hs_fall_n, hs_fall0, hs_fall1} = '0;
        {vs_low, vs_fall_n, vs_orphan, ls_2l, fs_cnt, ri_nz, cs_low0, cs_low3} = '0;
        first_ri_k = -1;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        prev_act = 1'b0;
        prev_rgb = 9'd0;

        for (int k = 0; k < K_STOP; k++) begin
            h_e = k % 384;
            v_e = k / 384;
            act_e = (h_e >= 64) && (h_e < 320) && (v_e >= 40) && (v_e < 248);
            if ((32'(vif.hcount) !== 32'(h_e)) || (32'(vif.vcount) !== 32'(v_e))) bad_hv++;
            if (vif.active !== act_e) bad_act++;
            if (vif.hsync_ext_n !== (h_e >= 29)) bad_hs++;
            if (vif.vsync_ext_n !== (v_e >= 3)) bad_vs++;
            if (vif.line_start !== (h_e == 0)) bad_ls++;
            if (vif.frame_start !== ((h_e == 0) && (v_e == 0))) bad_fs++;
            if (vif.csync_ext_n !== exp_csync(h_e, v_e, 384, 29, 312, 3)) bad_cs++;
            if ({vif.ri, vif.gi, vif.bi} !== (prev_act ? prev_rgb : 9'd0)) bad_rgb++;

            if ((k < 768) && !vif.hsync_ext_n) hs_low_2l++;
            if ((k < 768) && prev_hs && !vif.hsync_ext_n) begin
                if (hs_fall_n == 0) hs_fall0 = k;
                if (hs_fall_n == 1) hs_fall1 = k;
                hs_fall_n++;
            end
            if (!vif.vsync_ext_n) vs_low++;
            if (prev_vs && !vif.vsync_ext_n) begin
                vs_fall_n++;
                if (!(prev_hs && !vif.hsync_ext_n)) vs_orphan++;
            end
            if ((k < 768) && vif.line_start) ls_2l++;
            if (vif.frame_start) fs_cnt++;
            if ((vif.ri != 3'd0) && (first_ri_k < 0)) first_ri_k = k;
            if ((v_e >= 40) && (v_e < 60) && (vif.ri != 3'd0)) ri_nz++;
            if ((v_e == 0) && !vif.csync_ext_n) cs_low0++;
            if ((v_e == 3) && !vif.csync_ext_n) cs_low3++;

            prev_hs = vif.hsync_ext_n;
            prev_vs = vif.vsync_ext_n;
            prev_act = act_e;
            kb = 32'(k);
            rgb = (v_e < 60) ? 9'h1FF : {kb[2:0], ~kb[2:0], kb[5:3]};
            {vif.rin, vif.gin, vif.bin} = rgb;
            prev_rgb = rgb;
            tick();
        end

        check("track_hv", 32'(bad_hv), 0);
        check("track_active", 32'(bad_act), 0);
        check("track_hsync", 32'(bad_hs), 0);
        check("track_vsync", 32'(bad_vs), 0);
        check("track_line_start", 32'(bad_ls), 0);
        check("track_frame_start", 32'(bad_fs), 0);
        check("track_csync", 32'(bad_cs), 0);
        check("track_rgb", 32'(bad_rgb), 0);
        check("hsync_low_2lines", 32'(hs_low_2l), 58);
        check("hsync_falls_2lines", 32'(hs_fall_n), 2);
        check("hsync_fall_first", 32'(hs_fall0), 0);
        check("hsync_fall_period", 32'(hs_fall1 - hs_fall0), 384);
        check("line_start_2lines", 32'(ls_2l), 2);
        check("vsync_low_clk", 32'(vs_low), 1152);
        check("vsync_falls", 32'(vs_fall_n), 1);
        check("vsync_fall_off_hsync", 32'(vs_orphan), 0);
        check("frame_start_cnt", 32'(fs_cnt), 1);
        check("first_ri_pos", 32'(first_ri_k), 40 * 384 + 65);
        check("ri_nonzero_20lines", 32'(ri_nz), 20 * 256);
`ifdef CSYNC_SERRATION_EN
        check("csync_low_line0", 32'(cs_low0), 326);
        check("csync_low_line3", 32'(cs_low3), 28);
`else
        check("csync_low_line0", 32'(cs_low0), 384);
        check("csync_low_line3", 32'(cs_low3), 29);
`endif

        check("pre_rst_hcount", 32'(vif.hcount), 200);
        check("pre_rst_vcount", 32'(vif.vcount), 100);
        rst = 1'b1;
        tick();
        check("mid_rst_hcount", 32'(vif.hcount), 383);
        check("mid_rst_vcount", 32'(vif.vcount), 311);
        check("mid_rst_active", 32'(vif.active), 0);
        check("mid_rst_syncs", 32'({vif.hsync_ext_n, vif.vsync_ext_n, vif.csync_ext_n}), 7);
        check("mid_rst_rgb", 32'({vif.ri, vif.gi, vif.bi}), 0);
        rst = 1'b0;
        tick();
        check("resume_hv", 32'({vif.hcount, vif.vcount}), 0);
        check("resume_frame_start", 32'(vif.frame_start), 1);
        check("resume_syncs", 32'({vif.hsync_ext_n, vif.vsync_ext_n}), 0);
        tick();
        check("resume_step_hcount", 32'(vif.hcount), 1);
        check("resume_step_line_start", 32'(vif.line_start), 0);

        // Shrunken raster: 20 clocks x 12 lines, 240-clock frame.
        check("small_rst_hcount", 32'(sif.hcount), 19);
        check("small_rst_vcount", 32'(sif.vcount), 11);
        rst_s = 1'b0;
        tick();
        {bad_hv, bad_act, bad_hs, bad_vs, bad_ls, bad_fs, bad_cs, bad_rgb} = '0;
        fs_cnt = 0;
        prev_act = 1'b0;
        prev_rgb = 9'd0;
        for (int k = 0; k < 600; k++) begin
            h_e = k % 20;
            v_e = (k / 20) % 12;
            act_e = (h_e >= 5) && (h_e < 17) && (v_e >= 3) && (v_e < 9);
            if ((32'(sif.hcount) !== 32'(h_e)) || (32'(sif.vcount) !== 32'(v_e))) bad_hv++;
            if (sif.active !== act_e) bad_act++;
            if (sif.hsync_ext_n !== (h_e >= 4)) bad_hs++;
            if (sif.vsync_ext_n !== (v_e >= 2)) bad_vs++;
            if (sif.line_start !== (h_e == 0)) bad_ls++;
            if (sif.frame_start !== ((h_e == 0) && (v_e == 0))) bad_fs++;
            if (sif.csync_ext_n !== exp_csync(h_e, v_e, 20, 4, 12, 2)) bad_cs++;
            if ({sif.ri, sif.gi, sif.bi} !== (prev_act ? prev_rgb : 9'd0)) bad_rgb++;
            if (sif.frame_start) fs_cnt++;
            prev_act = act_e;
            kb = 32'(k);
            rgb = {kb[2:0], ~kb[4:2], kb[5:3]};
            {sif.rin, sif.gin, sif.bin} = rgb;
            prev_rgb = rgb;
            tick();
        end
        check("small_track_hv", 32'(bad_hv), 0);
        check("small_track_active", 32'(bad_act), 0);
        check("small_track_hsync", 32'(bad_hs), 0);
        check("small_track_vsync", 32'(bad_vs), 0);
        check("small_track_line_start", 32'(bad_ls), 0);
        check("small_track_frame_start", 32'(bad_fs), 0);
        check("small_track_csync", 32'(bad_cs), 0);
        check("small_track_rgb", 32'(bad_rgb), 0);
        check("small_frame_starts", 32'(fs_cnt), 3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
